tmds_encode_multi: RTL and testbench



---
 rtl/tmds_pkg.sv | 74 +++++++
 rtl/tmds_encode_multi_if.sv | 24 ++
 rtl/tmds_lane_encode.sv | 114 +++++++++++
 rtl/tmds_encode_multi.sv | 92 +++++++++
 tb/tb_tmds_encode_multi.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmds_pkg.sv
// Shared types, code tables and helpers for the multi-lane TMDS/TERC4 encoder.
// Code values are listed as encoded bit 9 down to bit 0, before any serialiser bit reversal.
package tmds_pkg;

    typedef enum logic [1:0] {
        DT_GUARD  = 2'b00,
        DT_CTRL   = 2'b01,
        DT_ISLAND = 2'b10,
        DT_PIXEL  = 2'b11
    } dtype_e;

    localparam int DISP_W = 5;

    localparam logic [9:0] GUARD_VID_EDGE = 10'h2CC;
    localparam logic [9:0] GUARD_COMMON   = 10'h133;

    // Per-lane side-band carried alongside the pixel data path.
    typedef struct packed {
        logic [1:0] ctl;
        logic [3:0] aux;
    } side_t;

    function automatic logic [9:0] ctl_code(input logic [1:0] c);
        logic [9:0] code;
        case (c)
            2'b00:   code = 10'h354;
            2'b01:   code = 10'h0AB;
            2'b10:   code = 10'h154;
            default: code = 10'h2AB;
        endcase
        return code;
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] n);
        logic [9:0] code;
        case (n)
            4'h0:    code = 10'h29C;
            4'h1:    code = 10'h263;
            4'h2:    code = 10'h2E4;
            4'h3:    code = 10'h2E2;
            4'h4:    code = 10'h171;
            4'h5:    code = 10'h11E;
            4'h6:    code = 10'h18E;
            4'h7:    code = 10'h13C;
            4'h8:    code = 10'h2CC;
            4'h9:    code = 10'h139;
            4'hA:    code = 10'h19C;
            4'hB:    code = 10'h2C6;
            4'hC:    code = 10'h28E;
            4'hD:    code = 10'h271;
            4'hE:    code = 10'h163;
            default: code = 10'h2C3;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    function automatic logic [9:0] rev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            r[i] = v[9-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/tmds_encode_multi_if.sv
// Framer-to-encoder bundle: shared symbol type, per-lane payloads and encoded words back.
interface tmds_encode_multi_if #(
    parameter int NCH = 3
);
    logic                i_ce;
    logic [1:0]          i_dtype;
    logic                i_island;
    logic [2*NCH-1:0]    i_ctl;
    logic [4*NCH-1:0]    i_aux;
    logic [8*NCH-1:0]    i_data;
    logic                o_valid;
    logic [10*NCH-1:0]   o_word;
    logic [5*NCH-1:0]    o_disparity;

    modport master (
        output i_ce, i_dtype, i_island, i_ctl, i_aux, i_data,
        input  o_valid, o_word, o_disparity
    );

    modport slave (
        input  i_ce, i_dtype, i_island, i_ctl, i_aux, i_data,
        output o_valid, o_word, o_disparity
    );
endinterface

// File: rtl/tmds_lane_encode.sv
// One TMDS lane: S1 transition minimisation, S2 DC balance with running disparity,
// and the combinational S3 symbol select that the top registers.
module tmds_lane_encode
    import tmds_pkg::*;
#(
    parameter int LANE                = 0,
    parameter bit OPT_DISPARITY_RESET = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_ce,
    input  dtype_e                   i_dtype_s1,
    input  dtype_e                   i_dtype_s2,
    input  logic                     i_island_s2,
    input  logic [1:0]               i_ctl,
    input  logic [3:0]               i_aux,
    input  logic [7:0]               i_data,
    output logic [9:0]               o_sym,
    output logic signed [DISP_W-1:0] o_cnt
);

    localparam int M = LANE % 3;

    side_t                     side_s1_q, side_s1_d;
    side_t                     side_s2_q, side_s2_d;
    logic [8:0]                qm_s1_q, qm_s1_d;
    logic [9:0]                enc_s2_q, enc_s2_d;
    logic signed [DISP_W-1:0]  cnt_q, cnt_d;

    logic [3:0]                n1_in;
    logic                      use_xnor;

    always_comb begin
        logic [8:0] chain;
        n1_in    = ones8(i_data);
        use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !i_data[0]);
        chain    = '0;
        chain[0] = i_data[0];
        for (int i = 1; i < 8; i++) begin
            chain[i] = use_xnor ? ~(chain[i-1] ^ i_data[i]) : (chain[i-1] ^ i_data[i]);
        end
        chain[8]  = ~use_xnor;
        qm_s1_d   = chain;
        side_s1_d = '{ctl: i_ctl, aux: i_aux};
    end

    logic                      q8;
    logic [7:0]                qv;
    logic [3:0]                n1_qm, n0_qm;
    logic signed [5:0]         diff, delta, cnt_sum;

    // Ones are counted over q_m, not the input byte: the balance decision depends on what is sent.
    always_comb begin
        q8        = qm_s1_q[8];
        qv        = qm_s1_q[7:0];
        n1_qm     = ones8(qv);
        n0_qm     = 4'd8 - n1_qm;
        diff      = $signed({2'b00, n1_qm}) - $signed({2'b00, n0_qm});
        enc_s2_d  = '0;
        delta     = 6'sd0;
        if ((cnt_q == 5'sd0) || (n1_qm == n0_qm)) begin
            enc_s2_d = {~q8, q8, q8 ? qv : ~qv};
            delta    = q8 ? diff : -diff;
        end else if (((cnt_q > 5'sd0) && (n1_qm > n0_qm)) ||
                     ((cnt_q < 5'sd0) && (n0_qm > n1_qm))) begin
            enc_s2_d = {1'b1, q8, ~qv};
            delta    = (q8 ? 6'sd2 : 6'sd0) - diff;
        end else begin
            enc_s2_d = {1'b0, q8, qv};
            delta    = (q8 ? 6'sd0 : -6'sd2) + diff;
        end
        cnt_sum = $signed({cnt_q[DISP_W-1], cnt_q}) + delta;
        cnt_d   = cnt_sum[DISP_W-1:0];
        if (i_dtype_s1 != DT_PIXEL) begin
            cnt_d = OPT_DISPARITY_RESET ? '0 : cnt_q;
        end
        side_s2_d = side_s1_q;
    end

    always_comb begin
        o_sym = ctl_code(side_s2_q.ctl);
        case (i_dtype_s2)
            DT_PIXEL:  o_sym = enc_s2_q;
            DT_ISLAND: o_sym = terc4_code(side_s2_q.aux);
            DT_GUARD: begin
                if (i_island_s2) begin
                    o_sym = (M == 0) ? terc4_code(side_s2_q.aux) : GUARD_COMMON;
                end else begin
                    o_sym = (M == 1) ? GUARD_COMMON : GUARD_VID_EDGE;
                end
            end
            default:   o_sym = ctl_code(side_s2_q.ctl);
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            side_s1_q <= '0;
            side_s2_q <= '0;
            qm_s1_q   <= '0;
            enc_s2_q  <= '0;
            cnt_q     <= '0;
        end else if (i_ce) begin
            side_s1_q <= side_s1_d;
            side_s2_q <= side_s2_d;
            qm_s1_q   <= qm_s1_d;
            enc_s2_q  <= enc_s2_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/tmds_encode_multi.sv
// NCH-lane TMDS/TERC4 encoder: shared type pipeline, output-valid priming,
// per-lane encoders and the final S3 register with optional serialiser bit reversal.
module tmds_encode_multi
    import tmds_pkg::*;
#(
    parameter int NCH                 = 3,
    parameter bit BIT_REVERSE         = 1'b1,
    parameter bit OPT_DISPARITY_RESET = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    tmds_encode_multi_if.slave   bus
);

    localparam logic [9:0] RST_LANE = BIT_REVERSE ? rev10(ctl_code(2'b00)) : ctl_code(2'b00);

    dtype_e                    dtype_s1_q, dtype_s1_d;
    dtype_e                    dtype_s2_q, dtype_s2_d;
    logic                      island_s1_q, island_s1_d;
    logic                      island_s2_q, island_s2_d;
    logic [1:0]                prime_q, prime_d;
    logic                      valid_q, valid_d;
    logic [10*NCH-1:0]         word_q, word_d;
    logic [DISP_W*NCH-1:0]     disp_q, disp_d;

    logic [9:0]                sym [NCH];
    logic signed [DISP_W-1:0]  cnt [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        tmds_lane_encode #(
            .LANE                (k),
            .OPT_DISPARITY_RESET (OPT_DISPARITY_RESET)
        ) u_lane (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_ce        (bus.i_ce),
            .i_dtype_s1  (dtype_s1_q),
            .i_dtype_s2  (dtype_s2_q),
            .i_island_s2 (island_s2_q),
            .i_ctl       (bus.i_ctl[2*k +: 2]),
            .i_aux       (bus.i_aux[4*k +: 4]),
            .i_data      (bus.i_data[8*k +: 8]),
            .o_sym       (sym[k]),
            .o_cnt       (cnt[k])
        );
    end

    // Priming saturates at 3; valid needs two prior enabled edges plus the current one.
    always_comb begin
        dtype_s1_d  = dtype_e'(bus.i_dtype);
        island_s1_d = bus.i_island;
        dtype_s2_d  = dtype_s1_q;
        island_s2_d = island_s1_q;
        prime_d     = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
        valid_d     = bus.i_ce && (prime_q >= 2'd2);
        word_d      = '0;
        disp_d      = '0;
        for (int k = 0; k < NCH; k++) begin
            word_d[10*k +: 10]         = BIT_REVERSE ? rev10(sym[k]) : sym[k];
            disp_d[DISP_W*k +: DISP_W] = cnt[k];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            dtype_s1_q  <= DT_CTRL;
            dtype_s2_q  <= DT_CTRL;
            island_s1_q <= 1'b0;
            island_s2_q <= 1'b0;
            prime_q     <= '0;
            valid_q     <= 1'b0;
            word_q      <= {NCH{RST_LANE}};
            disp_q      <= '0;
        end else begin
            valid_q <= valid_d;
            if (bus.i_ce) begin
                dtype_s1_q  <= dtype_s1_d;
                dtype_s2_q  <= dtype_s2_d;
                island_s1_q <= island_s1_d;
                island_s2_q <= island_s2_d;
                prime_q     <= prime_d;
                word_q      <= word_d;
                disp_q      <= disp_d;
            end
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_word      = word_q;
    assign bus.o_disparity = disp_q;

endmodule

// File: tb/tb_tmds_encode_multi.sv
// Bench for tmds_encode_multi: directed scenarios plus randomised traffic against a
// queue-based reference model of the encoding rules.
module tb_tmds_encode_multi;

    localparam int NCH = 3;
    localparam bit BR  = 1'b0;

    localparam logic [9:0] CTL_T [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    localparam logic [9:0] TERC_T [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2,
                                           10'h171, 10'h11E, 10'h18E, 10'h13C,
                                           10'h2CC, 10'h139, 10'h19C, 10'h2C6,
                                           10'h28E, 10'h271, 10'h163, 10'h2C3};

    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    tmds_encode_multi_if #(.NCH(NCH)) bus ();

    tmds_encode_multi #(
        .NCH                 (NCH),
        .BIT_REVERSE         (BR),
        .OPT_DISPARITY_RESET (1'b1)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [10*NCH-1:0] w;
        logic [5*NCH-1:0]  d;
        logic [8*NCH-1:0]  data;
        bit                pix;
    } ent_t;

    ent_t               pipe[$];
    int                 mcnt [NCH];
    int                 edges;
    logic [10*NCH-1:0]  exp_word;
    logic [5*NCH-1:0]   exp_disp;
    logic [8*NCH-1:0]   exp_data;
    bit                 exp_pix;
    logic               exp_valid;

    function automatic int popc8(input logic [7:0] v);
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'(v[i]);
        return s;
    endfunction

    function automatic logic [9:0] rev(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return r;
    endfunction

    function automatic logic [9:0] model_pixel(input logic [7:0] d, input int lane);
        logic [8:0] qm;
        logic [9:0] w;
        int n1, a, b, q8;
        bit use_xnor;
        n1 = popc8(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        q8 = int'(qm[8]);
        a = popc8(qm[7:0]);
        b = 8 - a;
        if (mcnt[lane] == 0 || a == b) begin
            w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt[lane] += (q8 == 1) ? (a - b) : (b - a);
        end else if ((mcnt[lane] > 0 && a > b) || (mcnt[lane] < 0 && b > a)) begin
            w = {1'b1, qm[8], ~qm[7:0]};
            mcnt[lane] += 2 * q8 + b - a;
        end else begin
            w = {1'b0, qm[8], qm[7:0]};
            mcnt[lane] += -2 * (1 - q8) + a - b;
        end
        return w;
    endfunction

    function automatic logic [9:0] model_sym(input int lane, input logic [1:0] dt, input bit isl,
                                             input logic [1:0] c, input logic [3:0] a,
                                             input logic [7:0] d);
        logic [9:0] w;
        int m;
        m = lane % 3;
        if (dt == 2'b11) begin
            w = model_pixel(d, lane);
        end else begin
            mcnt[lane] = 0;
            if (dt == 2'b01)      w = CTL_T[c];
            else if (dt == 2'b10) w = TERC_T[a];
            else if (isl)         w = (m == 0) ? TERC_T[a] : 10'h133;
            else                  w = (m == 1) ? 10'h133 : 10'h2CC;
        end
        return BR ? rev(w) : w;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] w);
        logic [7:0] v, d;
        v = w[9] ? ~w[7:0] : w[7:0];
        d[0] = v[0];
        for (int i = 1; i < 8; i++) d[i] = w[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        return d;
    endfunction

    task automatic reset_model();
        pipe.delete();
        for (int k = 0; k < NCH; k++) mcnt[k] = 0;
        edges     = 0;
        exp_word  = {NCH{BR ? rev(10'h354) : 10'h354}};
        exp_disp  = '0;
        exp_data  = '0;
        exp_pix   = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.i_ce = 1'b0; bus.i_dtype = 2'b01; bus.i_island = 1'b0;
        bus.i_ctl = '0; bus.i_aux = '0; bus.i_data = '0;
        i_reset = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        reset_model();
    endtask

    task automatic step(input bit ce, input logic [1:0] dt, input bit isl,
                        input logic [2*NCH-1:0] ctl, input logic [4*NCH-1:0] aux,
                        input logic [8*NCH-1:0] data);
        ent_t e;
        bus.i_ce = ce; bus.i_dtype = dt; bus.i_island = isl;
        bus.i_ctl = ctl; bus.i_aux = aux; bus.i_data = data;
        @(posedge i_clk);
        #1;
        if (ce) begin
            for (int k = 0; k < NCH; k++) begin
                e.w[10*k +: 10] = model_sym(k, dt, isl, ctl[2*k +: 2], aux[4*k +: 4], data[8*k +: 8]);
                e.d[5*k +: 5]   = mcnt[k][4:0];
            end
            e.data = data;
            e.pix  = (dt == 2'b11);
            pipe.push_back(e);
            edges++;
            if (pipe.size() == 3) begin
                e = pipe.pop_front();
                exp_word = e.w; exp_disp = e.d; exp_data = e.data; exp_pix = e.pix;
            end
        end
        exp_valid = ce && (edges >= 3);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.o_word !== {NCH{10'h354}}) begin bad++; $display("FAIL reset_word got=%h want=%h", bus.o_word, {NCH{10'h354}}); end
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.o_valid); end
        total++; if (bus.o_disparity !== '0) begin bad++; $display("FAIL reset_disp got=%h want=0", bus.o_disparity); end
    endtask

    task automatic test_pixel_zeros();
        logic [9:0] hw [3] = '{10'h100, 10'h3FF, 10'h100};
        logic [4:0] hd [3] = '{5'b11000, 5'b00010, 5'b11010};
        do_reset();
        for (int s = 1; s <= 5; s++) begin
            step(1'b1, 2'b11, 1'b0, '0, '0, '0);
            total++; if (bus.o_word !== exp_word) begin bad++; $display("FAIL zeros_word step=%0d got=%h want=%h", s, bus.o_word, exp_word); end
            total++; if (bus.o_valid !== (s >= 3)) begin bad++; $display("FAIL zeros_valid step=%0d got=%b want=%b", s, bus.o_valid, s >= 3); end
            if (s >= 3) begin
                total++; if (bus.o_word[9:0] !== hw[s-3]) begin bad++; $display("FAIL zeros_lane0 step=%0d got=%h want=%h", s, bus.o_word[9:0], hw[s-3]); end
                total++; if (bus.o_disparity[4:0] !== hd[s-3]) begin bad++; $display("FAIL zeros_disp step=%0d got=%0d want=%0d", s, $signed(bus.o_disparity[4:0]), $signed(hd[s-3])); end
            end
        end
    endtask

    task automatic test_ff_then_ctl();
        do_reset();
        step(1'b1, 2'b11, 1'b0, '0, '0, {NCH{8'hFF}});
        step(1'b1, 2'b01, 1'b0, {NCH{2'b10}}, '0, '0);
        step(1'b1, 2'b01, 1'b0, '0, '0, '0);
        total++; if (bus.o_word[9:0] !== 10'h200 || bus.o_disparity[4:0] !== 5'b11000) begin bad++; $display("FAIL ff_word got=%h/%0d want=200/-8", bus.o_word[9:0], $signed(bus.o_disparity[4:0])); end
        step(1'b1, 2'b01, 1'b0, '0, '0, '0);
        total++; if (bus.o_word[9:0] !== 10'h154 || bus.o_disparity[4:0] !== 5'd0) begin bad++; $display("FAIL ctl_after_ff got=%h/%0d want=154/0", bus.o_word[9:0], $signed(bus.o_disparity[4:0])); end
        total++; if (bus.o_word !== exp_word) begin bad++; $display("FAIL ff_model got=%h want=%h", bus.o_word, exp_word); end
    endtask

    task automatic test_control();
        logic [9:0] hx [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        logic [1:0] c;
        do_reset();
        for (int s = 1; s <= 6; s++) begin
            c = (s <= 4) ? 2'(s - 1) : 2'b00;
            step(1'b1, 2'b01, 1'b0, {NCH{c}}, 12'($urandom), 24'($urandom));
            if (s >= 3) begin
                total++; if (bus.o_word !== {NCH{hx[s-3]}}) begin bad++; $display("FAIL ctl_code step=%0d got=%h want=%h", s, bus.o_word, {NCH{hx[s-3]}}); end
            end
        end
    endtask

    task automatic test_guards();
        logic [4*NCH-1:0] aux;
        do_reset();
        aux = 12'($urandom);
        aux[3:0] = 4'hA;
        step(1'b1, 2'b00, 1'b1, '0, aux, '0);
        step(1'b1, 2'b00, 1'b0, '0, aux, '0);
        step(1'b1, 2'b01, 1'b0, '0, '0, '0);
        total++; if (bus.o_word !== {10'h133, 10'h133, 10'h19C}) begin bad++; $display("FAIL island_guard got=%h want=%h", bus.o_word, {10'h133, 10'h133, 10'h19C}); end
        step(1'b1, 2'b01, 1'b0, '0, '0, '0);
        total++; if (bus.o_word !== {10'h2CC, 10'h133, 10'h2CC}) begin bad++; $display("FAIL video_guard got=%h want=%h", bus.o_word, {10'h2CC, 10'h133, 10'h2CC}); end
    endtask

    task automatic test_ce_gating();
        bit cep [14] = '{1, 1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1};
        logic [7:0] ramp;
        ramp = 8'h10;
        do_reset();
        for (int s = 0; s < 14; s++) begin
            step(cep[s], 2'b11, 1'b0, '0, '0, {NCH{ramp}});
            if (cep[s]) ramp = ramp + 8'd37;
            total++; if (bus.o_word !== exp_word || bus.o_disparity !== exp_disp) begin bad++; $display("FAIL ce_hold step=%0d got=%h/%h want=%h/%h", s, bus.o_word, bus.o_disparity, exp_word, exp_disp); end
            total++; if (bus.o_valid !== exp_valid) begin bad++; $display("FAIL ce_valid step=%0d got=%b want=%b", s, bus.o_valid, exp_valid); end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int s = 0; s < 4; s++) step(1'b1, 2'b11, 1'b0, '0, '0, '0);
        total++; if (bus.o_disparity[4:0] !== 5'd2) begin bad++; $display("FAIL mid_pre_disp got=%0d want=2", $signed(bus.o_disparity[4:0])); end
        i_reset = 1'b1;
        #1;
        total++; if (bus.o_word !== {NCH{10'h354}} || bus.o_valid !== 1'b0 || bus.o_disparity !== '0) begin bad++; $display("FAIL mid_reset got=%h/%b/%h want=%h/0/0", bus.o_word, bus.o_valid, bus.o_disparity, {NCH{10'h354}}); end
        @(negedge i_clk);
        i_reset = 1'b0;
        reset_model();
        for (int s = 1; s <= 3; s++) begin
            step(1'b1, 2'b11, 1'b0, '0, '0, 24'($urandom));
            total++; if (bus.o_valid !== (s == 3)) begin bad++; $display("FAIL mid_reprime step=%0d got=%b want=%b", s, bus.o_valid, s == 3); end
        end
        total++; if (bus.o_word !== exp_word) begin bad++; $display("FAIL mid_word got=%h want=%h", bus.o_word, exp_word); end
    endtask

    task automatic test_random();
        logic [1:0] dt;
        int dv;
        int errs;
        errs = 0;
        do_reset();
        for (int s = 0; s < 4000; s++) begin
            dt = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11;
            step($urandom_range(0, 7) != 0, dt, 1'($urandom), 6'($urandom), 12'($urandom), 24'($urandom));
            total++;
            if (bus.o_word !== exp_word || bus.o_disparity !== exp_disp || bus.o_valid !== exp_valid) begin
                bad++;
                if (errs < 10) $display("FAIL rand_out step=%0d got=%h/%h/%b want=%h/%h/%b", s, bus.o_word, bus.o_disparity, bus.o_valid, exp_word, exp_disp, exp_valid);
                errs++;
            end
            for (int k = 0; k < NCH; k++) begin
                dv = int'($signed(bus.o_disparity[5*k +: 5]));
                total++;
                if (dv > 8 || dv < -8) begin bad++; $display("FAIL rand_bound step=%0d lane=%0d got=%0d want=|cnt|<=8", s, k, dv); end
                if (exp_pix && edges >= 3) begin
                    total++;
                    if (decode(BR ? rev(bus.o_word[10*k +: 10]) : bus.o_word[10*k +: 10]) !== exp_data[8*k +: 8]) begin
                        bad++;
                        $display("FAIL rand_decode step=%0d lane=%0d got=%h want=%h", s, k, decode(bus.o_word[10*k +: 10]), exp_data[8*k +: 8]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pixel_zeros();
        test_ff_then_ctl();
        test_control();
        test_guards();
        test_ce_gating();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
